// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common_pkg
// Shared types and constants for the shared-SRAM access path.
//   ram_seq_state_t : sequencer FSM states (IDLE, SETUP, ACTIVE, HOLD, DONE)
//   requester_t     : identity of the requester that owns the cycle in flight
//   RAM_ADDR_WIDTH  : default SRAM address width
//   RAM_DATA_WIDTH  : default SRAM data width
//   SLOT_CYCLES     : length of one bus slot in clocks
// -----------------------------------------------------------------------------
package common_pkg;

    localparam int RAM_ADDR_WIDTH = 17;
    localparam int RAM_DATA_WIDTH = 8;
    localparam int SLOT_CYCLES    = 64;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACTIVE,
        HOLD,
        DONE
    } ram_seq_state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_CPU,
        REQ_VIDEO,
        REQ_SPI
    } requester_t;

    // Largest of three phase lengths; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/ram_sequencer_if.sv
// -----------------------------------------------------------------------------
// ram_sequencer_if
// SRAM pin bundle between the sequencer (master) and the SRAM / board model
// (slave).
//   ram_addr_o    : SRAM address
//   ram_data_o    : write data towards the SRAM
//   ram_data_oe_o : 1 = sequencer drives the data bus
//   ram_we_n_o    : write enable, active-low
//   ram_oe_n_o    : output enable, active-low
//   ram_data_i    : read data from the SRAM
// -----------------------------------------------------------------------------
interface ram_sequencer_if
    import common_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
);

    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [DATA_WIDTH-1:0] ram_data_o;
    logic                  ram_data_oe_o;
    logic                  ram_we_n_o;
    logic                  ram_oe_n_o;
    logic [DATA_WIDTH-1:0] ram_data_i;

    modport master (
        output ram_addr_o,
        output ram_data_o,
        output ram_data_oe_o,
        output ram_we_n_o,
        output ram_oe_n_o,
        input  ram_data_i
    );

    modport slave (
        input  ram_addr_o,
        input  ram_data_o,
        input  ram_data_oe_o,
        input  ram_we_n_o,
        input  ram_oe_n_o,
        output ram_data_i
    );

endinterface

// File: rtl/ram_sequencer.sv
// -----------------------------------------------------------------------------
// ram_sequencer
// Runs one setup/strobe/hold SRAM cycle for whichever requester (CPU, video,
// SPI) owns the current bus slot. On a slot-start strobe in IDLE the one-hot
// grant selects a requester; if its request is pending, the request is latched
// and sequenced. Read data and a one-cycle done pulse go back to that
// requester. The block never arbitrates: grants come from slot timing.
//
// Request handshake: a requester raises <x>_valid_i with its address/command
// and holds all of them stable until its <x>_done_o pulses. The request is
// only sampled on a strobe where that requester holds the grant; a request
// raised mid-slot waits for its next granted strobe. Once latched, later
// changes on grant/request inputs do not affect the cycle in flight.
//
// Ports:
//   clock_i, reset_n_i          : clock, asynchronous active-low reset
//   strobe_i                    : slot-start pulse
//   <x>_grant_i                 : slot ownership (one-hot)
//   <x>_valid_i/_addr_i         : pending request and its address
//   cpu_/spi_ we_i, wdata_i     : write command and data (video is read-only)
//   <x>_done_o                  : one-cycle completion pulse
//   rdata_o                     : last read data, held until the next read
//   overrun_o                   : sticky, strobe seen while busy
//   state_o                     : current FSM state (debug)
//   ram                         : SRAM pin bundle (master side)
// -----------------------------------------------------------------------------
module ram_sequencer
    import common_pkg::*;
#(
    parameter int ADDR_WIDTH   = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH   = RAM_DATA_WIDTH,
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  strobe_i,

    input  logic                  cpu_grant_i,
    input  logic                  video_grant_i,
    input  logic                  spi_grant_i,

    input  logic                  cpu_valid_i,
    input  logic                  video_valid_i,
    input  logic                  spi_valid_i,

    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [ADDR_WIDTH-1:0] video_addr_i,
    input  logic [ADDR_WIDTH-1:0] spi_addr_i,

    input  logic                  cpu_we_i,
    input  logic                  spi_we_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    input  logic [DATA_WIDTH-1:0] spi_wdata_i,

    output logic                  cpu_done_o,
    output logic                  video_done_o,
    output logic                  spi_done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  overrun_o,
    output ram_seq_state_t        state_o,

    ram_sequencer_if.master       ram
);

    localparam int MAX_PHASE = max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES);
    localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

    // Elaboration-time parameter checks.
    if (SETUP_CYCLES < 1 || PULSE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_phase
        $error("ram_sequencer: every phase length must be at least 1");
    end
    if (SETUP_CYCLES + PULSE_CYCLES + HOLD_CYCLES + 2 > SLOT_CYCLES) begin : g_bad_slot
        $error("ram_sequencer: SRAM cycle does not fit inside one slot");
    end

    // ------------------------------------------------------------------
    // Request selection: inline one-hot mux. Zero or multiple grants
    // select nothing, so no cycle starts.
    // ------------------------------------------------------------------
    logic [2:0]            grant_vec;
    requester_t            sel_id;
    logic                  sel_valid;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  start;

    assign grant_vec = {spi_grant_i, video_grant_i, cpu_grant_i};

    always_comb begin
        sel_id    = REQ_NONE;
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        case (grant_vec)
            3'b001: begin
                sel_id    = REQ_CPU;
                sel_valid = cpu_valid_i;
                sel_addr  = cpu_addr_i;
                sel_we    = cpu_we_i;
                sel_wdata = cpu_wdata_i;
            end
            3'b010: begin
                sel_id    = REQ_VIDEO;
                sel_valid = video_valid_i;
                sel_addr  = video_addr_i;
            end
            3'b100: begin
                sel_id    = REQ_SPI;
                sel_valid = spi_valid_i;
                sel_addr  = spi_addr_i;
                sel_we    = spi_we_i;
                sel_wdata = spi_wdata_i;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register and phase counter. The counter is loaded with
    // (phase length - 1) on phase entry and counts down to zero.
    // ------------------------------------------------------------------
    ram_seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    requester_t            id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Next values of the registered SRAM controls. Registering them keeps
    // the pins glitch-free and lets reset force them inactive directly.
    logic                  we_n_d;
    logic                  oe_n_d;
    logic                  data_oe_d;
    logic                  done_d;
    logic                  capture;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start     = 1'b0;
        capture   = 1'b0;

        case (state_q)
            IDLE: begin
                if (strobe_i && sel_valid) begin
                    start   = 1'b1;
                    state_d = SETUP;
                    cnt_d   = CNT_W'(SETUP_CYCLES - 1);
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ACTIVE;
                    cnt_d   = CNT_W'(PULSE_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    // Last strobe cycle: sample the SRAM read data.
                    capture = !we_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // ACTIVE is only ever entered from SETUP, so the latched command
        // is already valid when these are evaluated.
        we_n_d    = !(state_d == ACTIVE && we_q);
        oe_n_d    = !(state_d == ACTIVE && !we_q);
        data_oe_d = start ? sel_we
                          : (we_q && (state_d == SETUP || state_d == ACTIVE ||
                                      state_d == HOLD));
        done_d    = (state_d == DONE);
    end

    // ------------------------------------------------------------------
    // Request latch. Write data only updates on writes so ram_data_o does
    // not follow unrelated read traffic.
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            id_q    <= REQ_NONE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (start) begin
            id_q   <= sel_id;
            addr_q <= sel_addr;
            we_q   <= sel_we;
            if (sel_we) begin
                wdata_q <= sel_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs.
    // ------------------------------------------------------------------
    logic                  we_n_q;
    logic                  oe_n_q;
    logic                  data_oe_q;
    logic                  cpu_done_q;
    logic                  video_done_q;
    logic                  spi_done_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  overrun_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            data_oe_q    <= 1'b0;
            cpu_done_q   <= 1'b0;
            video_done_q <= 1'b0;
            spi_done_q   <= 1'b0;
            rdata_q      <= '0;
            overrun_q    <= 1'b0;
        end else begin
            we_n_q       <= we_n_d;
            oe_n_q       <= oe_n_d;
            data_oe_q    <= data_oe_d;
            cpu_done_q   <= done_d && (id_q == REQ_CPU);
            video_done_q <= done_d && (id_q == REQ_VIDEO);
            spi_done_q   <= done_d && (id_q == REQ_SPI);
            if (capture) begin
                rdata_q <= ram.ram_data_i;
            end
            // A strobe while busy cannot be served; flag it until reset.
            if (strobe_i && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign ram.ram_addr_o    = addr_q;
    assign ram.ram_data_o    = wdata_q;
    assign ram.ram_data_oe_o = data_oe_q;
    assign ram.ram_we_n_o    = we_n_q;
    assign ram.ram_oe_n_o    = oe_n_q;

    assign cpu_done_o   = cpu_done_q;
    assign video_done_o = video_done_q;
    assign spi_done_o   = spi_done_q;
    assign rdata_o      = rdata_q;
    assign overrun_o    = overrun_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_ram_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ram_sequencer
// Directed bench for ram_sequencer with default timing (S=2, P=4, H=1).
// Cycle numbers below are relative to the cycle k in which strobe_i is high.
// -----------------------------------------------------------------------------
module tb_ram_sequencer;
    import common_pkg::*;

    localparam int AW = 17;
    localparam int DW = 8;
    localparam int S  = 2;
    localparam int P  = 4;
    localparam int H  = 1;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic          strobe = 1'b0;
    logic          cpu_grant = 1'b0, video_grant = 1'b0, spi_grant = 1'b0;
    logic          cpu_valid = 1'b0, video_valid = 1'b0, spi_valid = 1'b0;
    logic [AW-1:0] cpu_addr = '0, video_addr = '0, spi_addr = '0;
    logic          cpu_we = 1'b0, spi_we = 1'b0;
    logic [DW-1:0] cpu_wdata = '0, spi_wdata = '0;
    logic          cpu_done, video_done, spi_done;
    logic [DW-1:0] rdata;
    logic          overrun;
    ram_seq_state_t state;

    ram_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_bus ();

    ram_sequencer #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .SETUP_CYCLES(S),
        .PULSE_CYCLES(P),
        .HOLD_CYCLES (H)
    ) dut (
        .clock_i      (clock),
        .reset_n_i    (reset_n),
        .strobe_i     (strobe),
        .cpu_grant_i  (cpu_grant),
        .video_grant_i(video_grant),
        .spi_grant_i  (spi_grant),
        .cpu_valid_i  (cpu_valid),
        .video_valid_i(video_valid),
        .spi_valid_i  (spi_valid),
        .cpu_addr_i   (cpu_addr),
        .video_addr_i (video_addr),
        .spi_addr_i   (spi_addr),
        .cpu_we_i     (cpu_we),
        .spi_we_i     (spi_we),
        .cpu_wdata_i  (cpu_wdata),
        .spi_wdata_i  (spi_wdata),
        .cpu_done_o   (cpu_done),
        .video_done_o (video_done),
        .spi_done_o   (spi_done),
        .rdata_o      (rdata),
        .overrun_o    (overrun),
        .state_o      (state),
        .ram          (ram_bus)
    );

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected FSM state c cycles after the strobe cycle.
    function automatic ram_seq_state_t exp_state(input int c);
        if (c >= 1 && c <= S)                return SETUP;
        else if (c > S && c <= S + P)        return ACTIVE;
        else if (c > S + P && c <= S + P + H) return HOLD;
        else if (c == S + P + H + 1)         return DONE;
        else                                 return IDLE;
    endfunction

    function automatic logic in_active(input int c);
        return (c >= S + 1 && c <= S + P);
    endfunction

    initial begin
        ram_bus.ram_data_i = '0;

        // ---------------- reset ----------------
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst state %0d", i), state, IDLE);
            chk($sformatf("rst we_n %0d", i), ram_bus.ram_we_n_o, 1'b1);
            chk($sformatf("rst oe_n %0d", i), ram_bus.ram_oe_n_o, 1'b1);
        end
        chk("rst data_oe", ram_bus.ram_data_oe_o, 1'b0);
        chk("rst addr", ram_bus.ram_addr_o, 17'h0);
        chk("rst data_o", ram_bus.ram_data_o, 8'h0);
        chk("rst rdata", rdata, 8'h0);
        chk("rst dones", {cpu_done, video_done, spi_done}, 3'b000);
        chk("rst overrun", overrun, 1'b0);
        reset_n = 1'b1;
        tick();
        tick();

        // ---------------- CPU read 0x01234 -> 0xA5 ----------------
        cpu_grant = 1'b1;
        cpu_valid = 1'b1;
        cpu_addr  = 17'h01234;
        cpu_we    = 1'b0;
        ram_bus.ram_data_i = 8'hA5;
        strobe    = 1'b1;
        tick();
        strobe    = 1'b0;
        // Post-latch changes must not disturb the cycle in flight.
        cpu_grant = 1'b0;
        cpu_addr  = 17'h00ABC;
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("rd state c%0d", c), state, exp_state(c));
            chk($sformatf("rd oe_n c%0d", c), ram_bus.ram_oe_n_o, !in_active(c));
            chk($sformatf("rd we_n c%0d", c), ram_bus.ram_we_n_o, 1'b1);
            chk($sformatf("rd data_oe c%0d", c), ram_bus.ram_data_oe_o, 1'b0);
            chk($sformatf("rd addr c%0d", c), ram_bus.ram_addr_o, 17'h01234);
            chk($sformatf("rd cpu_done c%0d", c), cpu_done, (c == 8));
            chk($sformatf("rd rdata c%0d", c), rdata, (c >= 7) ? 8'hA5 : 8'h00);
            if (c == 8) cpu_valid = 1'b0;
            tick();
        end
        ram_bus.ram_data_i = 8'h77;

        // ---------------- SPI write 0x1FFFF <- 0x5A ----------------
        spi_grant = 1'b1;
        spi_valid = 1'b1;
        spi_addr  = 17'h1FFFF;
        spi_we    = 1'b1;
        spi_wdata = 8'h5A;
        strobe    = 1'b1;
        tick();
        strobe    = 1'b0;
        spi_wdata = 8'h00;
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("wr state c%0d", c), state, exp_state(c));
            chk($sformatf("wr data_oe c%0d", c), ram_bus.ram_data_oe_o, (c <= S + P + H));
            chk($sformatf("wr data_o c%0d", c), ram_bus.ram_data_o, 8'h5A);
            chk($sformatf("wr we_n c%0d", c), ram_bus.ram_we_n_o, !in_active(c));
            chk($sformatf("wr oe_n c%0d", c), ram_bus.ram_oe_n_o, 1'b1);
            chk($sformatf("wr addr c%0d", c), ram_bus.ram_addr_o, 17'h1FFFF);
            chk($sformatf("wr spi_done c%0d", c), spi_done, (c == 8));
            chk($sformatf("wr cpu_done c%0d", c), cpu_done, 1'b0);
            chk($sformatf("wr rdata c%0d", c), rdata, 8'hA5);
            if (c == 8) spi_valid = 1'b0;
            tick();
        end
        spi_grant = 1'b0;
        spi_we    = 1'b0;

        // ---------------- video granted, not valid ----------------
        video_grant = 1'b1;
        video_valid = 1'b0;
        video_addr  = 17'h00100;
        strobe      = 1'b1;
        tick();
        strobe      = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("vid state c%0d", c), state, IDLE);
            chk($sformatf("vid enables c%0d", c),
                {ram_bus.ram_we_n_o, ram_bus.ram_oe_n_o}, 2'b11);
            chk($sformatf("vid done c%0d", c), video_done, 1'b0);
            tick();
        end
        video_grant = 1'b0;

        // ---------------- two grants at strobe ----------------
        cpu_grant = 1'b1;
        cpu_valid = 1'b1;
        cpu_addr  = 17'h00200;
        spi_grant = 1'b1;
        spi_valid = 1'b1;
        strobe    = 1'b1;
        tick();
        strobe    = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("dual state c%0d", c), state, IDLE);
            chk($sformatf("dual enables c%0d", c),
                {ram_bus.ram_we_n_o, ram_bus.ram_oe_n_o, ram_bus.ram_data_oe_o}, 3'b110);
            chk($sformatf("dual dones c%0d", c), {cpu_done, spi_done}, 2'b00);
            tick();
        end
        chk("dual overrun", overrun, 1'b0);
        spi_grant = 1'b0;
        spi_valid = 1'b0;

        // ---------------- overrun during CPU read ----------------
        cpu_grant = 1'b1;
        cpu_valid = 1'b1;
        cpu_addr  = 17'h00042;
        cpu_we    = 1'b0;
        ram_bus.ram_data_i = 8'h3C;
        strobe    = 1'b1;
        tick();
        for (int c = 1; c <= 10; c++) begin
            strobe = (c == 4);
            chk($sformatf("ovr state c%0d", c), state, exp_state(c));
            chk($sformatf("ovr oe_n c%0d", c), ram_bus.ram_oe_n_o, !in_active(c));
            chk($sformatf("ovr cpu_done c%0d", c), cpu_done, (c == 8));
            chk($sformatf("ovr rdata c%0d", c), rdata, (c >= 7) ? 8'h3C : 8'hA5);
            chk($sformatf("ovr flag c%0d", c), overrun, (c >= 5));
            if (c == 8) cpu_valid = 1'b0;
            tick();
        end
        strobe    = 1'b0;
        cpu_grant = 1'b0;
        tick();
        tick();
        chk("ovr sticky", overrun, 1'b1);

        // ---------------- reset during SPI write ----------------
        spi_grant = 1'b1;
        spi_valid = 1'b1;
        spi_addr  = 17'h00155;
        spi_we    = 1'b1;
        spi_wdata = 8'hC3;
        strobe    = 1'b1;
        tick();
        strobe    = 1'b0;
        tick();
        tick();
        tick();
        // cycle k+4: mid strobe phase
        chk("mrst pre we_n", ram_bus.ram_we_n_o, 1'b0);
        chk("mrst pre data_oe", ram_bus.ram_data_oe_o, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst we_n", ram_bus.ram_we_n_o, 1'b1);
        chk("mrst oe_n", ram_bus.ram_oe_n_o, 1'b1);
        chk("mrst data_oe", ram_bus.ram_data_oe_o, 1'b0);
        chk("mrst state", state, IDLE);
        chk("mrst overrun", overrun, 1'b0);
        chk("mrst addr", ram_bus.ram_addr_o, 17'h0);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("post state c%0d", c), state, IDLE);
            chk($sformatf("post spi_done c%0d", c), spi_done, 1'b0);
            chk($sformatf("post we_n c%0d", c), ram_bus.ram_we_n_o, 1'b1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
